// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 1-to-4 TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned MISS_W    = 3;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Frame lock FSM for the TDM demultiplexer: slot counter, missing-sync
// flywheel counter and one-hot per-slot write strobes.
//   clk, rst       : clock, synchronous active-high reset
//   en, frame_sync : slot strobe and slot-0 marker
//   cnt            : slot the next EN sample is written to (registered)
//   locked         : high while in LOCKED (registered)
//   wr_stb_c       : one-hot write strobe for the current sample (comb)
//   sync_err_c     : current sample is a misaligned sync (comb)
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int unsigned MISS_MAX = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 frame_sync,
  output logic [SLOT_W-1:0]    cnt,
  output logic                 locked,
  output logic [NUM_SLOTS-1:0] wr_stb_c,
  output logic                 sync_err_c
);

  tdm_state_t        state, state_nxt;
  logic [SLOT_W-1:0] cnt_nxt;
  logic [MISS_W-1:0] miss, miss_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      cnt   <= '0;
      miss  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      miss  <= miss_nxt;
    end
  end

  // Next state and write strobes; EN=0 cycles leave everything untouched
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    miss_nxt   = miss;
    wr_stb_c   = '0;
    sync_err_c = 1'b0;
    if (en) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            wr_stb_c  = NUM_SLOTS'(1);
            cnt_nxt   = SLOT_W'(1);
            miss_nxt  = '0;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // Sync always restarts the frame; off slot 0 it is an error
            sync_err_c = (cnt != '0);
            wr_stb_c   = NUM_SLOTS'(1);
            cnt_nxt    = SLOT_W'(1);
            miss_nxt   = '0;
          end else if (cnt == '0) begin
            // miss never exceeds MISS_MAX, so inequality means "below"
            if (miss != MISS_W'(MISS_MAX)) begin
              wr_stb_c = NUM_SLOTS'(1);
              cnt_nxt  = SLOT_W'(1);
              miss_nxt = miss + MISS_W'(1);
            end else begin
              state_nxt = HUNT;
              cnt_nxt   = '0;
              miss_nxt  = '0;
            end
          end else begin
            // Slot 3 wraps to 0; its strobe triggers frame publication
            wr_stb_c = NUM_SLOTS'(1) << cnt;
            cnt_nxt  = cnt + SLOT_W'(1);
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: rtl/tdm_demux_1_4.sv
// Four-channel TDM demultiplexer: locks to FRAME_SYNC, collects slots 0..2
// in shadow registers and publishes all four channels on the slot-3 sample.
//   CLK, RST          : clock, synchronous active-high reset
//   EN                : slot strobe qualifying D_IN and FRAME_SYNC
//   D_IN, FRAME_SYNC  : slot data and slot-0 marker
//   OUT0..OUT3        : last complete frame
//   FRAME_VALID       : one-cycle pulse when OUT0..OUT3 update
//   LOCKED            : frame lock indicator
//   SYNC_ERR          : one-cycle pulse on a misaligned sync
//   CUR_SLOT          : slot the next EN sample is written to
module tdm_demux_1_4 #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned MISS_MAX = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic [WIDTH-1:0]          D_IN,
  input  logic                      FRAME_SYNC,
  output logic [WIDTH-1:0]          OUT0,
  output logic [WIDTH-1:0]          OUT1,
  output logic [WIDTH-1:0]          OUT2,
  output logic [WIDTH-1:0]          OUT3,
  output logic                      FRAME_VALID,
  output logic                      LOCKED,
  output logic                      SYNC_ERR,
  output logic [tdm_pkg::SLOT_W-1:0] CUR_SLOT
);

  import tdm_pkg::*;

  logic [NUM_SLOTS-1:0] wr_stb_c;
  logic                 sync_err_c;
  logic [WIDTH-1:0]     sh0, sh1, sh2;

  tdm_slot_ctr #(
    .MISS_MAX (MISS_MAX)
  ) u_slot_ctr (
    .clk        (CLK),
    .rst        (RST),
    .en         (EN),
    .frame_sync (FRAME_SYNC),
    .cnt        (CUR_SLOT),
    .locked     (LOCKED),
    .wr_stb_c   (wr_stb_c),
    .sync_err_c (sync_err_c)
  );

  // Shadow capture, frame publication and status pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      OUT0        <= '0;
      OUT1        <= '0;
      OUT2        <= '0;
      OUT3        <= '0;
      FRAME_VALID <= 1'b0;
      SYNC_ERR    <= 1'b0;
    end else begin
      FRAME_VALID <= 1'b0;
      SYNC_ERR    <= sync_err_c;
      if (wr_stb_c[0]) sh0 <= D_IN;
      if (wr_stb_c[1]) sh1 <= D_IN;
      if (wr_stb_c[2]) sh2 <= D_IN;
      if (wr_stb_c[3]) begin
        OUT0        <= sh0;
        OUT1        <= sh1;
        OUT2        <= sh2;
        OUT3        <= D_IN;
        FRAME_VALID <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Bench for tdm_demux_1_4: two instances (MISS_MAX=2 and MISS_MAX=0) share
// one stimulus stream and are compared every cycle against a frame model.
module tb_tdm_demux_1_4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] d = '0;

  logic [W-1:0] outs [2][4];
  logic         fv [2];
  logic         lk [2];
  logic         se [2];
  logic [1:0]   cs [2];

  int errors = 0;
  int checks = 0;

  // Reference model state, one copy per instance
  int mm [2] = '{2, 0};
  int m_sh [2][3];
  int m_out [2][4];
  int m_slot [2];
  int m_miss [2];
  bit m_lk [2];
  bit m_fv [2];
  bit m_se [2];

  always #5 clk = ~clk;

  tdm_demux_1_4 #(.WIDTH(W), .MISS_MAX(2)) u_dut_a (
    .CLK(clk), .RST(rst), .EN(en), .D_IN(d), .FRAME_SYNC(sync),
    .OUT0(outs[0][0]), .OUT1(outs[0][1]), .OUT2(outs[0][2]), .OUT3(outs[0][3]),
    .FRAME_VALID(fv[0]), .LOCKED(lk[0]), .SYNC_ERR(se[0]), .CUR_SLOT(cs[0])
  );

  tdm_demux_1_4 #(.WIDTH(W), .MISS_MAX(0)) u_dut_b (
    .CLK(clk), .RST(rst), .EN(en), .D_IN(d), .FRAME_SYNC(sync),
    .OUT0(outs[1][0]), .OUT1(outs[1][1]), .OUT2(outs[1][2]), .OUT3(outs[1][3]),
    .FRAME_VALID(fv[1]), .LOCKED(lk[1]), .SYNC_ERR(se[1]), .CUR_SLOT(cs[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One frame-level update of the model for a single clock edge
  task automatic model_edge(input int k, input bit r, input bit e, input bit s, input int dv);
    m_fv[k] = 1'b0;
    m_se[k] = 1'b0;
    if (r) begin
      for (int i = 0; i < 3; i++) m_sh[k][i] = 0;
      for (int i = 0; i < 4; i++) m_out[k][i] = 0;
      m_slot[k] = 0;
      m_miss[k] = 0;
      m_lk[k]   = 1'b0;
    end else if (e) begin
      if (!m_lk[k]) begin
        if (s) begin
          m_sh[k][0] = dv; m_slot[k] = 1; m_miss[k] = 0; m_lk[k] = 1'b1;
        end
      end else if (s) begin
        m_se[k] = (m_slot[k] != 0);
        m_sh[k][0] = dv; m_slot[k] = 1; m_miss[k] = 0;
      end else if (m_slot[k] == 0) begin
        if (m_miss[k] < mm[k]) begin
          m_sh[k][0] = dv; m_slot[k] = 1; m_miss[k]++;
        end else begin
          m_lk[k] = 1'b0; m_slot[k] = 0; m_miss[k] = 0;
        end
      end else if (m_slot[k] == 3) begin
        m_out[k] = '{m_sh[k][0], m_sh[k][1], m_sh[k][2], dv};
        m_fv[k]  = 1'b1;
        m_slot[k] = 0;
      end else begin
        m_sh[k][m_slot[k]] = dv;
        m_slot[k]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("u%0d_out%0d", k, i), 32'(outs[k][i]), 32'(m_out[k][i]));
      check($sformatf("u%0d_frame_valid", k), 32'(fv[k]), 32'(m_fv[k]));
      check($sformatf("u%0d_locked", k), 32'(lk[k]), 32'(m_lk[k]));
      check($sformatf("u%0d_sync_err", k), 32'(se[k]), 32'(m_se[k]));
      check($sformatf("u%0d_cur_slot", k), 32'(cs[k]), 32'(m_slot[k]));
    end
  endtask

  // Drive one cycle of inputs, advance model at the edge, compare at negedge
  task automatic step(input bit r, input bit e, input bit s, input logic [W-1:0] dv);
    rst = r; en = e; sync = s; d = dv;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, r, e, s, int'(dv));
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), W'($urandom));
  endtask

  task automatic frame(input bit s0, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] dd, input int gap);
    step(1'b0, 1'b1, s0, a);   idle(gap);
    step(1'b0, 1'b1, 1'b0, b); idle(gap);
    step(1'b0, 1'b1, 1'b0, c); idle(gap);
    step(1'b0, 1'b1, 1'b0, dd);
  endtask

  function automatic logic [15:0] out_word(input int k);
    return {outs[k][0], outs[k][1], outs[k][2], outs[k][3]};
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) model_edge(k, 1'b1, 1'b0, 1'b0, 0);

    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 4'hF);

    // Lock and first frame
    frame(1'b1, 4'hA, 4'hB, 4'hC, 4'hD, 0);
    check("lock_frame_out", 32'(out_word(0)), 32'h0000ABCD);
    check("lock_frame_fv", 32'(fv[0]), 32'd1);

    // Frame with EN gaps and toggling data
    frame(1'b1, 4'h1, 4'h2, 4'h3, 4'h4, 3);
    check("gap_frame_out", 32'(out_word(0)), 32'h00001234);

    // Misaligned sync
    step(1'b0, 1'b1, 1'b1, 4'h1);
    step(1'b0, 1'b1, 1'b0, 4'h2);
    step(1'b0, 1'b1, 1'b1, 4'h9);
    check("misalign_sync_err", 32'(se[0]), 32'd1);
    step(1'b0, 1'b1, 1'b0, 4'h8);
    step(1'b0, 1'b1, 1'b0, 4'h7);
    step(1'b0, 1'b1, 1'b0, 4'h6);
    check("misalign_next_out", 32'(out_word(0)), 32'h00009876);

    // Flywheel twice, then loss of lock on the third missing sync
    frame(1'b0, 4'h1, 4'h1, 4'h2, 4'h2, 0);
    check("fly1_out", 32'(out_word(0)), 32'h00001122);
    check("fly1_miss0_unlocked", 32'(lk[1]), 32'd0);
    frame(1'b0, 4'h3, 4'h3, 4'h4, 4'h4, 0);
    check("fly2_out", 32'(out_word(0)), 32'h00003344);
    step(1'b0, 1'b1, 1'b0, 4'h5);
    check("fly3_unlocked", 32'(lk[0]), 32'd0);
    check("fly3_out_held", 32'(out_word(0)), 32'h00003344);
    idle(2);

    // Reset mid-frame
    step(1'b0, 1'b1, 1'b1, 4'h1);
    step(1'b0, 1'b1, 1'b0, 4'h2);
    step(1'b0, 1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b1, 1'b0, 4'h4);
    check("rst_mid_out", 32'(out_word(0)), 32'h0);
    frame(1'b1, 4'h5, 4'h6, 4'h7, 4'h8, 0);
    check("rst_then_out", 32'(out_word(0)), 32'h00005678);

    // Randomized traffic: mostly aligned syncs with occasional faults
    for (int n = 0; n < 3000; n++) begin
      bit r, e, s;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 3) != 0);
      if (m_slot[0] == 0) s = ($urandom_range(0, 99) < 85);
      else                s = ($urandom_range(0, 99) < 3);
      step(r, e, s, W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
